// File: rtl/pk_serial_panel_pkg.sv
// Shared definitions for the serial control-panel front-end:
// command opcodes, function-key codes, rotary positions and TX state encoding.
package pk_defs;

    localparam logic [2:0] CMD_NOP    = 3'b000;
    localparam logic [2:0] CMD_FN     = 3'b001;
    localparam logic [2:0] CMD_KEYLO0 = 3'b010;
    localparam logic [2:0] CMD_KEYLO1 = 3'b011;
    localparam logic [2:0] CMD_KEYMID = 3'b100;
    localparam logic [2:0] CMD_KEYHI  = 3'b101;
    localparam logic [2:0] CMD_STAT   = 3'b110;
    localparam logic [2:0] CMD_ROT    = 3'b111;

    localparam logic [3:0] FN_RUN     = 4'd0;
    localparam logic [3:0] FN_HALT    = 4'd1;
    localparam logic [3:0] FN_CYCLE   = 4'd2;
    localparam logic [3:0] FN_STOPN   = 4'd3;
    localparam logic [3:0] FN_STEP    = 4'd4;
    localparam logic [3:0] FN_START   = 4'd5;
    localparam logic [3:0] FN_FETCH_I = 4'd6;
    localparam logic [3:0] FN_FETCH_D = 4'd7;
    localparam logic [3:0] FN_STORE_I = 4'd8;
    localparam logic [3:0] FN_STORE_D = 4'd9;
    localparam logic [3:0] FN_LOAD    = 4'd10;
    localparam logic [3:0] FN_CLEAR   = 4'd11;

    localparam logic [3:0] ROT_R0 = 4'd0;
    localparam logic [3:0] ROT_R1 = 4'd1;
    localparam logic [3:0] ROT_R2 = 4'd2;
    localparam logic [3:0] ROT_R3 = 4'd3;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_e;

endpackage

// File: rtl/pk_serial_panel_if.sv
// UART-side byte handshake between the UART core and the panel front-end.
interface pk_serial_panel_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       tx_busy;
    logic [7:0] tx_byte;
    logic       tx_send;

    modport master (output rx_byte, rx_valid, tx_busy, input tx_byte, tx_send);
    modport slave  (input rx_byte, rx_valid, tx_busy, output tx_byte, tx_send);
endinterface

// File: rtl/pk_serial_panel_status_tx.sv
// Status streamer: snapshots the live status on request and sends it byte by
// byte over the UART handshake, with one-deep request queueing and a timeout.
module pk_status_tx
    import pk_defs::*;
#(
    parameter int N_STAT     = 4,
    parameter int TX_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_i,
    input  logic [8*N_STAT-1:0]   status_i,
    input  logic                  tx_busy_i,
    output logic [7:0]            tx_byte_o,
    output logic                  tx_send_o,
    output logic                  tx_err_o
);

    localparam int IDX_W = (N_STAT > 1) ? $clog2(N_STAT) : 1;
    localparam int TMR_W = $clog2(TX_TIMEOUT + 1);

    tx_state_e           state_q;
    logic [8*N_STAT-1:0] snap_q;
    logic [IDX_W-1:0]    idx_q;
    logic [TMR_W-1:0]    tmr_q;
    logic                pend_q;
    logic                send_q;
    logic                err_q;
    logic [7:0]          byte_q;
    logic                last_idx;

    assign last_idx  = (idx_q == IDX_W'(N_STAT - 1));
    assign tx_byte_o = byte_q;
    assign tx_send_o = send_q;
    assign tx_err_o  = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            pend_q  <= 1'b0;
            send_q  <= 1'b0;
            byte_q  <= 8'h00;
            err_q   <= 1'b0;
            idx_q   <= '0;
            tmr_q   <= '0;
        end else begin
            if (req_i && state_q != TX_IDLE)
                pend_q <= 1'b1;
            case (state_q)
                TX_IDLE: begin
                    if (tx_busy_i) begin
                        if (req_i)
                            pend_q <= 1'b1;
                    end else if (req_i || pend_q) begin
                        snap_q  <= status_i;
                        idx_q   <= '0;
                        // a fresh request arriving while the queued one is served stays queued
                        pend_q  <= pend_q & req_i;
                        state_q <= TX_LOAD;
                    end
                end
                TX_LOAD: begin
                    byte_q  <= snap_q[8*(N_STAT-1-int'(idx_q)) +: 8];
                    send_q  <= 1'b1;
                    tmr_q   <= '0;
                    state_q <= TX_WAIT_BUSY;
                end
                TX_WAIT_BUSY: begin
                    if (tx_busy_i) begin
                        send_q  <= 1'b0;
                        state_q <= TX_WAIT_DONE;
                    end else if (tmr_q == TMR_W'(TX_TIMEOUT - 1)) begin
                        send_q  <= 1'b0;
                        err_q   <= 1'b1;
                        pend_q  <= 1'b0;
                        state_q <= TX_IDLE;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                TX_WAIT_DONE: begin
                    if (!tx_busy_i) begin
                        if (last_idx) begin
                            state_q <= TX_IDLE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= TX_LOAD;
                        end
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pk_serial_panel.sv
// Panel front-end: decodes UART command bytes into function keys, data keys and
// rotary position, and hands status requests to the status streamer.
module pk_serial_panel
    import pk_defs::*;
#(
    parameter int          N_STAT     = 4,
    parameter int          PULSE_CYC  = 1,
    parameter logic [15:0] MONO_MASK  = 16'h0FF8,
    parameter logic [3:0]  ROT_INIT   = ROT_R1,
    parameter int          TX_TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    pk_serial_panel_if.slave    bus,
    input  logic [8*N_STAT-1:0] status,
    output logic [15:0]         fnkey,
    output logic [15:0]         keys,
    output logic [3:0]          rotary_pos,
    output logic                tx_err
);

    localparam int PC_W = $clog2(PULSE_CYC + 1);

    logic [15:0]     fn_q, fn_d;
    logic [15:0]     keys_q, keys_d;
    logic [3:0]      rot_q, rot_d;
    logic [PC_W-1:0] cnt_q, cnt_d;
    logic [2:0]      cmd;
    logic [3:0]      fn_idx;
    logic            stat_req;
    logic [7:0]      tx_byte_w;
    logic            tx_send_w;

    assign cmd      = bus.rx_byte[7:5];
    assign fn_idx   = bus.rx_byte[4:1];
    assign stat_req = bus.rx_valid && (cmd == CMD_STAT);

    always_comb begin
        fn_d   = fn_q;
        keys_d = keys_q;
        rot_d  = rot_q;
        cnt_d  = cnt_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - PC_W'(1);
            if (cnt_q == PC_W'(1))
                fn_d = fn_q & ~MONO_MASK;
        end
        // decoded after expiry so a simultaneous mono set wins
        if (bus.rx_valid) begin
            case (cmd)
                CMD_FN: begin
                    fn_d[fn_idx] = bus.rx_byte[0];
                    if (bus.rx_byte[0] && MONO_MASK[fn_idx])
                        cnt_d = PC_W'(PULSE_CYC);
                end
                CMD_KEYLO0, CMD_KEYLO1: keys_d[5:0]   = bus.rx_byte[5:0];
                CMD_KEYMID:             keys_d[10:6]  = bus.rx_byte[4:0];
                CMD_KEYHI:              keys_d[15:11] = bus.rx_byte[4:0];
                CMD_ROT:                rot_d         = bus.rx_byte[3:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fn_q   <= '0;
            keys_q <= '0;
            rot_q  <= ROT_INIT;
            cnt_q  <= '0;
        end else begin
            fn_q   <= fn_d;
            keys_q <= keys_d;
            rot_q  <= rot_d;
            cnt_q  <= cnt_d;
        end
    end

    assign fnkey       = fn_q;
    assign keys        = keys_q;
    assign rotary_pos  = rot_q;
    assign bus.tx_byte = tx_byte_w;
    assign bus.tx_send = tx_send_w;

    pk_status_tx #(
        .N_STAT     (N_STAT),
        .TX_TIMEOUT (TX_TIMEOUT)
    ) u_status_tx (
        .clk       (clk),
        .rst       (rst),
        .req_i     (stat_req),
        .status_i  (status),
        .tx_busy_i (bus.tx_busy),
        .tx_byte_o (tx_byte_w),
        .tx_send_o (tx_send_w),
        .tx_err_o  (tx_err)
    );

endmodule

// File: tb/tb_pk_serial_panel.sv
// Bench for pk_serial_panel: behavioural key/rotary model and a byte scoreboard
// for status transfers, driven by directed scenarios plus random command traffic.
module tb_pk_serial_panel;
    import pk_defs::*;

    localparam int          N_STAT     = 4;
    localparam int          PULSE_CYC  = 3;
    localparam int          TX_TIMEOUT = 20;
    localparam int          BUSY_CYC   = 10;
    localparam logic [15:0] MONO_MASK  = 16'h0FF8;
    localparam logic [3:0]  ROT_INIT   = 4'd1;

    logic                clk = 1'b0;
    logic                rst;
    logic [8*N_STAT-1:0] status;
    logic [15:0]         fnkey, keys;
    logic [3:0]          rotary_pos;
    logic                tx_err;

    pk_serial_panel_if bus();

    pk_serial_panel #(
        .N_STAT(N_STAT), .PULSE_CYC(PULSE_CYC), .MONO_MASK(MONO_MASK),
        .ROT_INIT(ROT_INIT), .TX_TIMEOUT(TX_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .status(status),
        .fnkey(fnkey), .keys(keys), .rotary_pos(rotary_pos), .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Key/rotary model: absolute-time deadline for monostable keys
    logic [15:0] m_fn, m_keys;
    logic [3:0]  m_rot;
    logic [7:0]  mb;
    longint      edge_n = 0;
    longint      deadline = -1;
    bit          cmp_en = 0;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            m_fn = '0; m_keys = '0; m_rot = ROT_INIT; deadline = -1;
        end else begin
            if (edge_n == deadline)
                m_fn = m_fn & ~MONO_MASK;
            if (bus.rx_valid) begin
                mb = bus.rx_byte;
                case (mb[7:5])
                    3'd1: begin
                        m_fn[mb[4:1]] = mb[0];
                        if (mb[0] && MONO_MASK[mb[4:1]])
                            deadline = edge_n + PULSE_CYC;
                    end
                    3'd2, 3'd3: m_keys[5:0]   = mb[5:0];
                    3'd4:       m_keys[10:6]  = mb[4:0];
                    3'd5:       m_keys[15:11] = mb[4:0];
                    3'd7:       m_rot         = mb[3:0];
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("fnkey", {16'h0, fnkey}, {16'h0, m_fn});
            chk("keys", {16'h0, keys}, {16'h0, m_keys});
            chk("rotary_pos", {28'h0, rotary_pos}, {28'h0, m_rot});
        end
    end

    // Transfer scoreboard: one in flight, at most one queued
    logic [7:0] exp_q[$];
    logic [7:0] log_q[$];
    bit         m_busy = 0;
    bit         m_pend = 0;
    int         tx_rises = 0;
    logic       prev_send = 1'b0;

    task automatic push_status();
        for (int k = 0; k < N_STAT; k++)
            exp_q.push_back(status[8*(N_STAT-k)-1 -: 8]);
    endtask

    always @(negedge clk) begin
        if (bus.tx_send === 1'b1 && prev_send !== 1'b1) begin
            tx_rises++;
            log_q.push_back(bus.tx_byte);
            if (exp_q.size() == 0) begin
                chk("tx_unexpected_send", {24'h0, bus.tx_byte}, 32'hFFFF_FFFF);
            end else begin
                chk("tx_byte", {24'h0, bus.tx_byte}, {24'h0, exp_q.pop_front()});
                if (exp_q.size() == 0) begin
                    if (m_pend) begin
                        m_pend = 0;
                        push_status();
                    end else begin
                        m_busy = 0;
                    end
                end
            end
        end
        prev_send = bus.tx_send;
    end

    // UART transmitter model
    bit stuck = 0;
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_send && !bus.tx_busy && !stuck) begin
                bus.tx_busy = 1'b1;
                repeat (BUSY_CYC) @(negedge clk);
                bus.tx_busy = 1'b0;
            end
        end
    end

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic issue_req();
        if (!m_busy) begin
            m_busy = 1;
            push_status();
        end else if (!m_pend) begin
            m_pend = 1;
        end
        send_rx(8'hC0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_busy || bus.tx_busy || bus.tx_send) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait_in_budget", {31'h0, n < budget}, 32'h1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int base, n;
        rst = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'h00;
        status = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        chk("rst_fnkey", {16'h0, fnkey}, 32'h0);
        chk("rst_keys", {16'h0, keys}, 32'h0);
        chk("rst_rot", {28'h0, rotary_pos}, 32'h1);
        chk("rst_tx_send", {31'h0, bus.tx_send}, 32'h0);
        chk("rst_tx_byte", {24'h0, bus.tx_byte}, 32'h0);
        chk("rst_tx_err", {31'h0, tx_err}, 32'h0);
        rst = 1'b0;
        cmp_en = 1;

        // FN_STEP monostable pulse of PULSE_CYC cycles
        send_rx(8'h20 | (8'(FN_STEP) << 1) | 8'h01);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("mono_step_pulse", {31'h0, fnkey[4]}, {31'h0, i < 3});
        end

        // data keys and rotary
        send_rx(8'h5A);
        send_rx(8'h95);
        send_rx(8'hB3);
        chk("keys_literal", {16'h0, keys}, 32'h9D5A);
        send_rx(8'hEB);
        chk("rotary_literal", {28'h0, rotary_pos}, 32'hB);

        // random command traffic, status requests excluded
        repeat (300) begin
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) < 5)
                b[7:5] = 3'd1;
            else if (b[7:5] == CMD_STAT)
                b[7:5] = CMD_ROT;
            send_rx(b);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        // status snapshot, latency and mid-transfer change
        repeat (5) @(negedge clk);
        status = 32'hDEADBEEF;
        log_q.delete();
        issue_req();
        chk("latency_pre", {31'h0, bus.tx_send}, 32'h0);
        @(negedge clk);
        chk("latency_2cyc", {31'h0, bus.tx_send}, 32'h1);
        status = 32'h12345678;
        wait_idle(400);
        chk("snap_len", log_q.size(), 4);
        if (log_q.size() == 4) begin
            chk("snap_b0", {24'h0, log_q[0]}, 32'hDE);
            chk("snap_b1", {24'h0, log_q[1]}, 32'hAD);
            chk("snap_b2", {24'h0, log_q[2]}, 32'hBE);
            chk("snap_b3", {24'h0, log_q[3]}, 32'hEF);
        end

        // two requests during a transfer -> exactly one extra transfer
        base = tx_rises;
        issue_req();
        n = 0;
        while (tx_rises == base && n < 50) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        issue_req();
        issue_req();
        wait_idle(600);
        repeat (30) @(negedge clk);
        chk("queued_xfer_bytes", tx_rises - base, 8);
        chk("tx_err_clean", {31'h0, tx_err}, 32'h0);

        // handshake timeout
        stuck = 1;
        issue_req();
        n = 0;
        while (!bus.tx_send && n < 50) begin @(negedge clk); n++; end
        n = 0;
        while (bus.tx_send && n < 200) begin n++; @(negedge clk); end
        chk("timeout_len", n, TX_TIMEOUT);
        chk("tx_err_set", {31'h0, tx_err}, 32'h1);
        exp_q.delete();
        m_busy = 0;
        m_pend = 0;
        stuck = 0;
        repeat (3) @(negedge clk);
        base = tx_rises;
        issue_req();
        wait_idle(400);
        chk("after_timeout_xfer", tx_rises - base, 4);
        chk("tx_err_sticky", {31'h0, tx_err}, 32'h1);

        // reset while waiting for the UART to finish a byte
        send_rx(8'hBF);
        issue_req();
        n = 0;
        while (!(bus.tx_busy && !bus.tx_send) && n < 60) begin @(negedge clk); n++; end
        send_rx(8'h20 | (8'(FN_START) << 1) | 8'h01);
        chk("start_set", {31'h0, fnkey[5]}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        m_busy = 0;
        m_pend = 0;
        chk("rst2_fnkey", {16'h0, fnkey}, 32'h0);
        chk("rst2_keys", {16'h0, keys}, 32'h0);
        chk("rst2_rot", {28'h0, rotary_pos}, 32'h1);
        chk("rst2_tx_send", {31'h0, bus.tx_send}, 32'h0);
        chk("rst2_tx_byte", {24'h0, bus.tx_byte}, 32'h0);
        chk("rst2_tx_err", {31'h0, tx_err}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        base = tx_rises;
        repeat (40) @(negedge clk);
        chk("no_send_after_rst", tx_rises - base, 0);

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
